// File: rtl/intr_timer_unit_if.sv
// Data-bus register port of the interrupt/timer unit: single-cycle write and
// read strobes, word address, and registered read data.
`timescale 1ns/1ps

interface intr_timer_unit_if;
    logic        io_we;
    logic        io_re;
    logic [2:0]  io_adr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_we, io_re, io_adr, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_we, io_re, io_adr, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/intr_timer_unit.sv
// Memory-mapped mtime/mtimecmp timer with prescaler plus a small external
// interrupt pending/enable unit. Optional macro INTR_TIMER_SNAPSHOT_EN adds an atomic HI-read shadow.
`timescale 1ns/1ps

module intr_timer_unit #(
    parameter int PRESCALE_W = 8,
    parameter int EXT_IRQ_N  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    intr_timer_unit_if.slave     bus,
    input  logic [EXT_IRQ_N-1:0] ext_irq_in,
    output logic                 frc_cntr_val_leq,
    output logic                 g_interrupt,
    output logic                 g_interrupt_1shot
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_PEND     = 3'd5;
    localparam logic [2:0] A_EN       = 3'd6;
    localparam logic [2:0] A_MODE     = 3'd7;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  ctrl_en_q, ctrl_en_d;
    logic [PRESCALE_W-1:0] ctrl_div_q, ctrl_div_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  leq_q, leq_d;
    logic [EXT_IRQ_N-1:0]  sync1_q, sync2_q, sync3_q;
    logic [EXT_IRQ_N-1:0]  pend_q, pend_d;
    logic [EXT_IRQ_N-1:0]  en_q, en_d;
    logic [EXT_IRQ_N-1:0]  mode_q, mode_d;
    logic                  gint_q, gint_d, gint_dly_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_val;
    logic [31:0]           mtime_hi_rd;
    logic [EXT_IRQ_N-1:0]  rise, w1c;
    logic                  tick;

    function automatic logic wr_hit(input logic [2:0] a);
        return bus.io_we && (bus.io_adr == a);
    endfunction

`ifdef INTR_TIMER_SNAPSHOT_EN
    // LO read latches the upper half so a following HI read cannot see a carry.
    logic [31:0] shadow_q, shadow_d;
    assign shadow_d    = (bus.io_re && bus.io_adr == A_MTIME_LO) ? mtime_q[63:32] : shadow_q;
    assign mtime_hi_rd = shadow_q;

    always_ff @(posedge clk) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
    end
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        tick    = ctrl_en_q && (presc_q == ctrl_div_q);
        presc_d = presc_q;
        if (wr_hit(A_CTRL))
            presc_d = '0;
        else if (ctrl_en_q)
            presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);

        // A bus write to either half drops that cycle's increment entirely.
        mtime_d = mtime_q;
        if (tick)               mtime_d = mtime_q + 64'd1;
        if (wr_hit(A_MTIME_LO)) mtime_d = {mtime_q[63:32], bus.io_wdata};
        if (wr_hit(A_MTIME_HI)) mtime_d = {bus.io_wdata, mtime_q[31:0]};

        cmp_d = cmp_q;
        if (wr_hit(A_CMP_LO)) cmp_d = {cmp_q[63:32], bus.io_wdata};
        if (wr_hit(A_CMP_HI)) cmp_d = {bus.io_wdata, cmp_q[31:0]};

        ctrl_en_d  = ctrl_en_q;
        ctrl_div_d = ctrl_div_q;
        if (wr_hit(A_CTRL)) begin
            ctrl_en_d  = bus.io_wdata[0];
            ctrl_div_d = bus.io_wdata[8 +: PRESCALE_W];
        end

        en_d   = wr_hit(A_EN)   ? bus.io_wdata[EXT_IRQ_N-1:0] : en_q;
        mode_d = wr_hit(A_MODE) ? bus.io_wdata[EXT_IRQ_N-1:0] : mode_q;
        w1c    = wr_hit(A_PEND) ? bus.io_wdata[EXT_IRQ_N-1:0] : '0;
        rise   = sync2_q & ~sync3_q;
        for (int i = 0; i < EXT_IRQ_N; i++)
            pend_d[i] = mode_q[i] ? ((pend_q[i] & ~w1c[i]) | rise[i]) : sync2_q[i];

        leq_d  = (cmp_q <= mtime_q);
        gint_d = |(pend_q & en_q);

        rd_val = '0;
        case (bus.io_adr)
            A_MTIME_LO: rd_val = mtime_q[31:0];
            A_MTIME_HI: rd_val = mtime_hi_rd;
            A_CMP_LO:   rd_val = cmp_q[31:0];
            A_CMP_HI:   rd_val = cmp_q[63:32];
            A_CTRL: begin
                rd_val[0]              = ctrl_en_q;
                rd_val[8 +: PRESCALE_W] = ctrl_div_q;
            end
            A_PEND:     rd_val[EXT_IRQ_N-1:0] = pend_q;
            A_EN:       rd_val[EXT_IRQ_N-1:0] = en_q;
            A_MODE:     rd_val[EXT_IRQ_N-1:0] = mode_q;
            default:    rd_val = '0;
        endcase
        rdata_d = bus.io_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            cmp_q      <= '1;
            ctrl_en_q  <= 1'b0;
            ctrl_div_q <= '0;
            presc_q    <= '0;
            leq_q      <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            mode_q     <= '0;
            gint_q     <= 1'b0;
            gint_dly_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_div_q <= ctrl_div_d;
            presc_q    <= presc_d;
            leq_q      <= leq_d;
            sync1_q    <= ext_irq_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pend_q     <= pend_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            gint_q     <= gint_d;
            gint_dly_q <= gint_q;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.io_rdata        = rdata_q;
    assign frc_cntr_val_leq    = leq_q;
    assign g_interrupt         = gint_q;
    assign g_interrupt_1shot   = gint_q & ~gint_dly_q;

endmodule

// File: tb/tb_intr_timer_unit.sv
// Directed bench for intr_timer_unit: prescaled counting, compare latency,
// carry/wrap, edge/level interrupts and reset priority.
`timescale 1ns/1ps

module tb_intr_timer_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ext_irq_in = '0;
    logic       leq, gint, g1;
    logic [31:0] d;
    int checks = 0;
    int errors = 0;

    intr_timer_unit_if bus();

    intr_timer_unit #(.PRESCALE_W(8), .EXT_IRQ_N(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .ext_irq_in        (ext_irq_in),
        .frc_cntr_val_leq  (leq),
        .g_interrupt       (gint),
        .g_interrupt_1shot (g1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] data);
        bus.io_we = 1'b1; bus.io_adr = adr; bus.io_wdata = data;
        @(negedge clk);
        bus.io_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [31:0] exp);
        bus.io_re = 1'b1; bus.io_adr = adr;
        @(negedge clk);
        bus.io_re = 1'b0;
        check(tag, bus.io_rdata, exp);
    endtask

    initial begin
        bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_adr = '0; bus.io_wdata = '0;
        idle(3);
        rst = 1'b0;
        check("rst_rdata", bus.io_rdata, 0);
        check("rst_leq", leq, 0);
        check("rst_gint", gint, 0);
        check("rst_1shot", g1, 0);
        rd_chk("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);

        // 1: prescaled count, div = 3
        wr(3'd4, 32'hFFFF_FFFF);
        rd_chk("ctrl_mask", 3'd4, 32'h0000_FF01);
        wr(3'd4, 32'h0000_0301);
        idle(40);
        wr(3'd4, 32'h0);
        rd_chk("div3_lo", 3'd0, 32'd10);
        idle(5);
        rd_chk("div3_hold", 3'd0, 32'd10);

        // 2: compare latency
        wr(3'd0, 32'h0);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h1);
        idle(5);
        check("leq_before", leq, 0);
        idle(1);
        check("leq_rise", leq, 1);
        wr(3'd2, 32'hFFFF_FFFF);
        check("leq_hold", leq, 1);
        idle(1);
        check("leq_fall", leq, 0);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'h0);
        check("leq_low", leq, 0);

        // 3: carry, wrap, write-wins
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        idle(1);
        wr(3'd4, 32'h0);
        rd_chk("carry_lo", 3'd0, 32'h0);
        rd_chk("carry_hi", 3'd1, 32'h1);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'h1);
        wr(3'd4, 32'h0);
        rd_chk("wrap_lo", 3'd0, 32'h0);
        rd_chk("wrap_hi", 3'd1, 32'h0);
        wr(3'd4, 32'h1);
        wr(3'd0, 32'h100);
        wr(3'd4, 32'h0);
        rd_chk("wr_wins", 3'd0, 32'h101);

        // 4: edge mode
        wr(3'd7, 32'h3);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("en_mask", 3'd6, 32'hF);
        ext_irq_in = 4'b0001;
        idle(1);
        ext_irq_in = '0;
        idle(1);
        check("edge_g_c1", gint, 0);
        idle(1);
        check("edge_g_c2", gint, 0);
        idle(1);
        check("edge_g_c3", gint, 1);
        check("edge_1shot", g1, 1);
        idle(1);
        check("edge_g_c4", gint, 1);
        check("edge_1shot_off", g1, 0);
        rd_chk("edge_pend", 3'd5, 32'h1);
        ext_irq_in = 4'b0010;
        idle(1);
        ext_irq_in = '0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("no_2nd_pulse", g1, 0);
        end
        rd_chk("edge_pend2", 3'd5, 32'h3);
        wr(3'd5, 32'h3);
        check("w1c_g_hold", gint, 1);
        idle(1);
        check("w1c_g_drop", gint, 0);
        rd_chk("w1c_pend", 3'd5, 32'h0);

        // 5: level mode
        wr(3'd7, 32'h0);
        wr(3'd6, 32'h4);
        ext_irq_in = 4'b0100;
        idle(5);
        rd_chk("lvl_pend", 3'd5, 32'h4);
        check("lvl_g", gint, 1);
        wr(3'd5, 32'h4);
        rd_chk("lvl_w1c", 3'd5, 32'h4);
        ext_irq_in = '0;
        idle(2);
        rd_chk("lvl_c3_old", 3'd5, 32'h4);
        rd_chk("lvl_clear", 3'd5, 32'h0);
        check("lvl_g_drop", gint, 0);
        bus.io_we = 1'b1; bus.io_re = 1'b1; bus.io_adr = 3'd6; bus.io_wdata = 32'h1;
        idle(1);
        bus.io_we = 1'b0; bus.io_re = 1'b0;
        check("wr_rd_old", bus.io_rdata, 32'h4);
        rd_chk("wr_rd_new", 3'd6, 32'h1);

        // 6: reset priority
        wr(3'd7, 32'hF);
        wr(3'd6, 32'hF);
        ext_irq_in = 4'hF;
        idle(1);
        ext_irq_in = '0;
        idle(5);
        check("pre_rst_g", gint, 1);
        rd_chk("pre_rst_pend", 3'd5, 32'hF);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h1);
        idle(2);
        check("pre_rst_leq", leq, 1);
        rst = 1'b1;
        bus.io_we = 1'b1; bus.io_re = 1'b1; bus.io_adr = 3'd4; bus.io_wdata = 32'h301;
        idle(1);
        rst = 1'b0; bus.io_we = 1'b0; bus.io_re = 1'b0;
        check("post_rdata", bus.io_rdata, 0);
        check("post_leq", leq, 0);
        check("post_gint", gint, 0);
        check("post_1shot", g1, 0);
        rd_chk("post_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd_chk("post_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd_chk("post_ctrl", 3'd4, 32'h0);
        rd_chk("post_pend", 3'd5, 32'h0);
        rd_chk("post_mode", 3'd7, 32'h0);
        rd_chk("post_mtime", 3'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
